// File: rtl/lc3_mem_arb_pkg.sv
// Shared types and constants for the LC3 memory arbiter.
package lc3_mem_arb_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;

  // Arbiter FSM encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Data side wins a contested slot unless fetch has been starved too long.
  function automatic logic pick_data(input logic i_req, input logic d_req,
                                     input logic starved);
    return d_req && !(i_req && starved);
  endfunction

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Bundle of fetch, data and memory signals around the arbiter.
// slave  : the arbiter's view.
// master : the surrounding requesters and memory model.
interface lc3_mem_arbiter_if
  import lc3_mem_arb_pkg::*;
#(
  parameter int ADDR_W = LC3_ADDR_W,
  parameter int DATA_W = LC3_DATA_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lc3_mem_arb_starve.sv
// Saturating count of consecutive arbitrations fetch has lost to data.
module lc3_mem_arb_starve #(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic win_i,
  input  logic lose_i,
  input  logic clear_i,
  output logic starved_o
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  // Next count: a fetch win or an idle fetch side restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (win_i || clear_i) begin
      cnt_d = '0;
    end else if (lose_i && (cnt_q < LIM)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q >= LIM);

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Two-requester arbiter in front of a single-ported LC3 memory.
// One access in flight at a time: IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP.
// Arbitration only in IDLE and RESP, so back-to-back accesses cost MEM_LAT+2 cycles.
module lc3_mem_arbiter
  import lc3_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = LC3_ADDR_W,
  parameter int DATA_W       = LC3_DATA_W,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  lc3_mem_arbiter_if.slave       bus,
  output logic                   busy_o
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        lat_q, lat_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic arb_en;
  logic any_req;
  logic starved;
  logic data_wins;
  logic st_issue;
  logic st_resp;

  assign arb_en    = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign any_req   = bus.i_req || bus.d_req;
  assign data_wins = pick_data(bus.i_req, bus.d_req, starved);

  lc3_mem_arb_starve #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .win_i     (arb_en && bus.i_req && !data_wins),
    .lose_i    (arb_en && bus.i_req && data_wins),
    .clear_i   (arb_en && !bus.i_req),
    .starved_o (starved)
  );

  // Next-state: latch the winner on arbitration, time the memory, capture read data.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lat_d     = lat_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (any_req) begin
          state_d = ST_ISSUE;
          owner_d = data_wins ? OWN_D : OWN_I;
          we_d    = data_wins && bus.d_we;
          addr_d  = data_wins ? bus.d_addr : bus.i_addr;
          wdata_d = data_wins ? bus.d_wdata : '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        lat_d   = LAT_LOAD;
      end
      ST_WAIT: begin
        if (lat_q == 3'd0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d = we_q ? '0 : bus.mem_rdata;
          end else begin
            i_rdata_d = bus.mem_rdata;
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lat_q     <= lat_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign st_issue = (state_q == ST_ISSUE);
  assign st_resp  = (state_q == ST_RESP);

  assign bus.i_gnt     = st_issue && (owner_q == OWN_I);
  assign bus.d_gnt     = st_issue && (owner_q == OWN_D);
  assign bus.mem_en    = st_issue;
  assign bus.mem_we    = st_issue && we_q;
  assign bus.mem_addr  = st_issue ? addr_q : '0;
  assign bus.mem_wdata = st_issue ? wdata_q : '0;

  assign bus.i_rvalid  = st_resp && (owner_q == OWN_I);
  assign bus.d_rvalid  = st_resp && (owner_q == OWN_D);
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  assign busy_o = st_issue || (state_q == ST_WAIT);

endmodule
